// File: rtl/snn_timestep_scheduler.sv
// Wishbone-programmable timestep sequencer for the dual-core SNN datapath.
// Runs LATCH -> CALC (per enabled core, every axon) -> CAPTURE -> NEXT for num_ts timesteps.
module snn_timestep_scheduler #(
  parameter int unsigned NUM_AXONS = 256,
  parameter int unsigned NUM_CORE  = 2,
  parameter logic [31:0] CTRL_BASE = 32'h8006_0000
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  output logic [NUM_CORE-1:0]           calc_en_o,
  output logic [$clog2(NUM_AXONS)-1:0]  axon_idx_o,
  output logic                          axon_valid_o,
  input  logic                          calc_stall_i,
  output logic                          spike_latch_o,
  output logic                          spike_capture_o,
  output logic                          done_irq_o
);

  localparam int unsigned AW = $clog2(NUM_AXONS);
  localparam int unsigned CW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CALC,
    S_CAPTURE,
    S_NEXT
  } state_t;

  state_t              state;
  logic [NUM_CORE-1:0] mask_q, mask_sh, new_mask;
  logic [7:0]          nts_q, nts_sh, new_nts;
  logic [7:0]          ts_done_q;
  logic                done_q, err_q, busy;
  logic [CW-1:0]       cur_core, first_core, next_core;
  logic                has_next, first_found;

  logic hit_ctrl, hit_stat, req, wr;
  logic start_wr, abort_wr, done_clr;
  logic [31:0] ctrl_rd, status_rd;
  logic unused_wb_bits;

  assign hit_ctrl = (wbs_adr_i == CTRL_BASE);
  assign hit_stat = (wbs_adr_i == CTRL_BASE + 32'd4);
  assign req      = wbs_cyc_i & wbs_stb_i & (hit_ctrl | hit_stat);
  // Writes commit at the edge closing the ack cycle, so a start lands in LATCH right after ack.
  assign wr       = wbs_ack_o & req & wbs_we_i;

  assign start_wr = wr & hit_ctrl & wbs_sel_i[0] & wbs_dat_i[0];
  assign abort_wr = wr & hit_ctrl & wbs_sel_i[0] & wbs_dat_i[1];
  assign done_clr = wr & hit_stat & wbs_sel_i[0] & wbs_dat_i[1];

  assign new_mask = wbs_sel_i[0] ? wbs_dat_i[NUM_CORE+1:2] : mask_q;
  assign new_nts  = wbs_sel_i[1] ? wbs_dat_i[15:8] : nts_q;
  assign unused_wb_bits = ^{wbs_dat_i, wbs_sel_i};

  assign busy       = (state != S_IDLE);
  assign done_irq_o = done_q;

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[15:8] = nts_q;
    ctrl_rd[NUM_CORE+1:2] = mask_q;
    status_rd = {16'h0, ts_done_q, 5'h0, err_q, done_q, busy};
  end

  always_comb begin
    first_core  = '0;
    first_found = 1'b0;
    next_core   = '0;
    has_next    = 1'b0;
    for (int unsigned i = 0; i < NUM_CORE; i++) begin
      if (mask_sh[i] && !first_found) begin
        first_core  = CW'(i);
        first_found = 1'b1;
      end
      if (mask_sh[i] && (i > 32'(cur_core)) && !has_next) begin
        next_core = CW'(i);
        has_next  = 1'b1;
      end
    end
  end

  function automatic logic [NUM_CORE-1:0] onehot(input logic [CW-1:0] c);
    onehot = '0;
    onehot[c] = 1'b1;
  endfunction

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req & ~wbs_ack_o;
      wbs_dat_o <= (req & ~wbs_ack_o & ~wbs_we_i) ? (hit_ctrl ? ctrl_rd : status_rd) : '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state           <= S_IDLE;
      mask_q          <= '0;
      nts_q           <= '0;
      mask_sh         <= '0;
      nts_sh          <= '0;
      ts_done_q       <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      cur_core        <= '0;
      calc_en_o       <= '0;
      axon_idx_o      <= '0;
      axon_valid_o    <= 1'b0;
      spike_latch_o   <= 1'b0;
      spike_capture_o <= 1'b0;
    end else begin
      spike_latch_o   <= 1'b0;
      spike_capture_o <= 1'b0;
      if (wr && hit_ctrl) begin
        mask_q <= new_mask;
        nts_q  <= new_nts;
      end
      if (done_clr) done_q <= 1'b0;

      if (state == S_IDLE) begin
        if (start_wr) begin
          if ((new_mask != '0) && (new_nts != '0)) begin
            mask_sh       <= new_mask;
            nts_sh        <= new_nts;
            ts_done_q     <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            spike_latch_o <= 1'b1;
            state         <= S_LATCH;
          end else begin
            err_q <= 1'b1;
          end
        end
      end else if (abort_wr) begin
        state        <= S_IDLE;
        calc_en_o    <= '0;
        axon_idx_o   <= '0;
        axon_valid_o <= 1'b0;
      end else begin
        unique case (state)
          S_LATCH: begin
            cur_core     <= first_core;
            calc_en_o    <= onehot(first_core);
            axon_idx_o   <= '0;
            axon_valid_o <= 1'b1;
            state        <= S_CALC;
          end
          S_CALC: begin
            if (!calc_stall_i) begin
              if (axon_idx_o == AW'(NUM_AXONS - 1)) begin
                axon_idx_o <= '0;
                if (has_next) begin
                  cur_core  <= next_core;
                  calc_en_o <= onehot(next_core);
                end else begin
                  calc_en_o       <= '0;
                  axon_valid_o    <= 1'b0;
                  spike_capture_o <= 1'b1;
                  state           <= S_CAPTURE;
                end
              end else begin
                axon_idx_o <= axon_idx_o + AW'(1);
              end
            end
          end
          S_CAPTURE: begin
            ts_done_q <= ts_done_q + 8'd1;
            state     <= S_NEXT;
          end
          S_NEXT: begin
            if (ts_done_q == nts_sh) begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              spike_latch_o <= 1'b1;
              state         <= S_LATCH;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Self-checking bench: Wishbone-driven runs compared against a queue of expected per-cycle outputs.
module tb_snn_timestep_scheduler;

  localparam logic [31:0] CB = 32'h8006_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat_w = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic [1:0]  calc_en;
  logic [7:0]  idx;
  logic        valid, stall = 1'b0, latch, capture, irq;

  int total = 0;
  int bad   = 0;
  int latch_cnt = 0, cap_cnt = 0, en0_cnt = 0;
  logic [13:0] q[$];

  snn_timestep_scheduler #(.NUM_AXONS(256), .NUM_CORE(2), .CTRL_BASE(CB)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .calc_en_o(calc_en), .axon_idx_o(idx), .axon_valid_o(valid),
    .calc_stall_i(stall), .spike_latch_o(latch), .spike_capture_o(capture),
    .done_irq_o(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (latch)   latch_cnt <= latch_cnt + 1;
    if (capture) cap_cnt   <= cap_cnt + 1;
    if (calc_en == 2'b01) en0_cnt <= en0_cnt + 1;
  end

  function automatic logic [13:0] pk(logic i, logic l, logic c, logic v, logic [1:0] e, logic [7:0] x);
    return {i, l, c, v, e, x};
  endfunction

  function automatic logic [13:0] obs();
    return {irq, latch, capture, valid, calc_en, idx};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cyc = 1; stb = 1; we = 1; adr = a; dat_w = d; sel = s;
    tick();
    while (!ack && n < 8) begin tick(); n++; end
    check("wr_ack", {31'h0, ack}, 32'h1);
    tick();
    cyc = 0; stb = 0; we = 0; sel = '0;
    check("wr_ack_single", {31'h0, ack}, 32'h0);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hF;
    tick();
    while (!ack && n < 8) begin tick(); n++; end
    check("rd_ack", {31'h0, ack}, 32'h1);
    d = dat_r;
    tick();
    cyc = 0; stb = 0;
    check("rd_ack_single", {31'h0, ack}, 32'h0);
  endtask

  // Expected output sequence of a whole run, one entry per cycle starting at LATCH.
  task automatic build(input logic [1:0] mask, input logic [7:0] nts);
    q.delete();
    for (int t = 0; t < int'(nts); t++) begin
      q.push_back(pk(0, 1, 0, 0, 2'b00, 8'd0));
      for (int c = 0; c < 2; c++)
        if (mask[c])
          for (int a = 0; a < 256; a++) q.push_back(pk(0, 0, 0, 1, 2'(1 << c), 8'(a)));
      q.push_back(pk(0, 0, 1, 0, 2'b00, 8'd0));
      q.push_back(pk(0, 0, 0, 0, 2'b00, 8'd0));
    end
  endtask

  task automatic run_check(input logic [1:0] mask, input logic [7:0] nts,
                           input int stall_pos, input int stall_len, input string tag);
    int pos = 0, rem = stall_len, mism = 0, n = 0;
    logic [13:0] fo = '0, fe = '0;
    logic [31:0] d;
    build(mask, nts);
    wb_write(CB, {16'h0, nts, 4'h0, mask, 2'b01}, 4'hF);
    while (q.size() > 0 && n < 6000) begin
      if (obs() !== q[0]) begin
        if (mism == 0) begin fo = obs(); fe = q[0]; end
        mism++;
      end
      if (pos == stall_pos && rem > 0) begin
        stall = 1; rem--;
      end else begin
        stall = 0; void'(q.pop_front()); pos++;
      end
      tick(); n++;
    end
    stall = 0;
    total++;
    assert (mism === 0 && q.size() == 0) else begin
      bad++;
      $error("FAIL %s_trace bad_cycles=%0d left=%0d first got=%h want=%h", tag, mism, q.size(), fo, fe);
    end
    check({tag, "_done_irq"}, {31'h0, irq}, 32'h1);
    wb_read(CB + 4, d);
    check({tag, "_status"}, d, {16'h0, nts, 8'h02});
    wb_read(CB, d);
    check({tag, "_ctrl"}, d, {16'h0, nts, 4'h0, mask, 2'b00});
  endtask

  initial begin
    logic [31:0] d;
    int l0, c0, e0, n, k, cnt;
    logic [1:0] m;
    logic [7:0] t;

    repeat (3) tick();
    rst = 0;
    tick();
    check("reset_outputs", {18'h0, obs()}, 32'h0);
    check("reset_ack", {31'h0, ack}, 32'h0);
    wb_read(CB + 4, d); check("reset_status", d, 32'h0);
    wb_read(CB, d);     check("reset_ctrl", d, 32'h0);

    // Byte lanes: only byte 1 written, no start.
    wb_write(CB, 32'h0000_0504, 4'b0010);
    wb_read(CB, d); check("sel_lane_ctrl", d, 32'h0000_0500);
    check("sel_lane_idle", {18'h0, obs()}, 32'h0);

    run_check(2'b11, 8'd1, -1, 0, "run_m3_t1");
    wb_write(CB + 4, 32'h2, 4'hF);
    wb_read(CB + 4, d); check("w1c_done", d, 32'h0000_0100);
    check("w1c_irq", {31'h0, irq}, 32'h0);

    run_check(2'b10, 8'd3, -1, 0, "run_m2_t3");
    run_check(2'b11, 8'd1, 256, 5, "stall_last_axon");

    for (int r = 0; r < 3; r++) begin
      m = 2'($urandom_range(1, 3));
      t = 8'($urandom_range(1, 3));
      k = int'(m[0]) + int'(m[1]);
      run_check(m, t, int'($urandom_range(1, k * 256)), int'($urandom_range(0, 4)), "rand_run");
    end

    // Abort at axon 100 of the second timestep.
    l0 = latch_cnt;
    wb_write(CB, 32'h0000_030D, 4'hF);
    n = 0;
    while (!(latch_cnt - l0 == 2 && calc_en == 2'b01 && idx == 8'd100) && n < 3000) begin
      tick(); n++;
    end
    check("abort_reach", {31'h0, n < 3000}, 32'h1);
    c0 = cap_cnt - 1;
    wb_write(CB, 32'h0000_030E, 4'hF);
    check("abort_outputs", {18'h0, obs()}, 32'h0);
    repeat (20) tick();
    check("abort_no_capture", 32'(cap_cnt - c0), 32'd1);
    wb_read(CB + 4, d); check("abort_status", d, 32'h0000_0100);

    wb_write(CB, 32'h0000_0101, 4'hF);
    wb_read(CB + 4, d); check("err_mask0", d, 32'h0000_0104);
    check("err_idle_outputs", {18'h0, obs()}, 32'h0);

    // Start while busy must be ignored; shadow copies keep mask=2, num_ts=1.
    l0 = latch_cnt; c0 = cap_cnt; e0 = en0_cnt;
    wb_write(CB, 32'h0000_0109, 4'hF);
    repeat (10) tick();
    wb_write(CB, 32'h0000_0205, 4'hF);
    n = 0;
    while (!irq && n < 600) begin tick(); n++; end
    check("busy_start_done", {31'h0, irq}, 32'h1);
    check("busy_start_latches", 32'(latch_cnt - l0), 32'd1);
    check("busy_start_captures", 32'(cap_cnt - c0), 32'd1);
    check("busy_start_core0", 32'(en0_cnt - e0), 32'd0);
    wb_read(CB + 4, d); check("busy_start_status", d, 32'h0000_0102);
    wb_read(CB, d);     check("busy_start_ctrl", d, 32'h0000_0204);

    cyc = 1; stb = 1; we = 0; adr = CB + 8; sel = 4'hF;
    cnt = 0;
    repeat (6) begin tick(); if (ack) cnt++; end
    cyc = 0; stb = 0;
    check("bad_addr_no_ack", 32'(cnt), 32'd0);

    // Asynchronous reset in the middle of a run.
    wb_write(CB, 32'h0000_010D, 4'hF);
    repeat (50) tick();
    #2 rst = 1;
    #1 check("async_rst_outputs", {18'h0, obs()}, 32'h0);
    l0 = latch_cnt; c0 = cap_cnt;
    repeat (3) tick();
    rst = 0;
    repeat (5) tick();
    check("async_rst_pulses", 32'((latch_cnt - l0) + (cap_cnt - c0)), 32'd0);
    check("async_rst_idle", {18'h0, obs()}, 32'h0);
    wb_read(CB + 4, d); check("async_rst_status", d, 32'h0);
    wb_read(CB, d);     check("async_rst_ctrl", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_timestep_scheduler.md
# snn_timestep_scheduler

Wishbone-programmable sequencer that drives the dual-core SNN datapath through whole timesteps. The host programs a timestep count and core mask, then starts a run. The block latches input spikes, sweeps every axon through each enabled core in turn, captures output spikes, and repeats until the count is exhausted. It sits on the Wishbone bus next to the input-spike, parameter and output-spike memories, and replaces address-decoded compute enables with a deterministic schedule.

## Interface
- NUM_AXONS, 256: axons swept per core per timestep; must be a power of two.
- NUM_CORE, 2: number of cores sequenced; core_mask width.
- CTRL_BASE, 32'h80060000: CTRL register address; STATUS is at CTRL_BASE+4.
- wb_clk_i  in  1  single clock; all logic rising-edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1 each  Wishbone cycle, strobe, write-enable.
- wbs_sel_i  in  4  byte lanes; a register byte is written only when its lane is set.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  read data; 0 when not acking.
- calc_en_o  out  NUM_CORE  one-hot enable for the core currently integrating.
- axon_idx_o  out  log2(NUM_AXONS)  axon index presented to the enabled core.
- axon_valid_o  out  1  axon_idx_o is valid this cycle.
- calc_stall_i  in  1  when high, the current axon is held and not consumed.
- spike_latch_o  out  1  one-cycle pulse: input-spike memory latches the next timestep's spikes.
- spike_capture_o  out  1  one-cycle pulse: output-spike memory captures core outputs.
- done_irq_o  out  1  level; equals STATUS.done.

## Operation
- CTRL (RW):
  - bit0 start: write-1 pulse, reads 0.
  - bit1 abort: write-1 pulse, reads 0.
  - bits[NUM_CORE+1:2] core_mask.
  - bits[15:8] num_ts.
- STATUS (RO, except W1C on bit1):
  - bit0 busy.
  - bit1 done: sticky; cleared by writing 1 or by an accepted start.
  - bit2 err: sticky; cleared by an accepted start.
  - bits[15:8] ts_done: timesteps completed.
- Start acceptance:
  - Accepted only in IDLE with core_mask≠0 and num_ts≠0.
  - Start with mask=0 or num_ts=0 sets err and stays IDLE.
  - Start while busy is ignored, with no err.
  - The register fields written in the same access are used.
- FSM states: IDLE, LATCH, CALC, CAPTURE, NEXT.
  - IDLE→LATCH on accepted start; ts_done←0.
  - LATCH: spike_latch_o=1 for one cycle; go to CALC on the lowest set core in core_mask; axon counter←0.
  - CALC: calc_en_o=one-hot(cur_core), axon_valid_o=1, axon_idx_o=counter.
    - If calc_stall_i=0, the counter increments.
    - At counter=NUM_AXONS-1 the counter wraps to 0 and cur_core advances to the next set mask bit (ascending). If none remain, go to CAPTURE.
    - If calc_stall_i=1, all outputs hold.
  - CAPTURE: spike_capture_o=1 for one cycle; ts_done increments; go to NEXT.
  - NEXT: if ts_done==num_ts, set done and go to IDLE; else go to LATCH.
- Abort in any non-IDLE state: go to IDLE next cycle. All strobes and enables drop, done is not set, and ts_done holds its partial value.
- core_mask and num_ts writes while busy update the register but take effect only at the next accepted start (latched shadow copies).

## Timing
- Reset values: all outputs 0; CTRL fields 0; STATUS 0; state IDLE.
- Wishbone:
  - wbs_ack_o asserts the cycle after cyc&stb with address CTRL_BASE or CTRL_BASE+4.
  - wbs_ack_o is high for exactly one cycle and never on back-to-back cycles of the same request.
  - Writes take effect on the ack cycle; read data is valid with ack.
  - Other addresses are never acked.
- Start written with ack at cycle t: LATCH at t+1, first CALC cycle at t+2.
- Unstalled timestep length = 1 + k·NUM_AXONS + 2 cycles (k = popcount(mask)). For k=2: 515 cycles.
- done/done_irq_o rise on the cycle after NEXT. busy falls on the same edge.
- A stall on the last axon holds the core switch until the stall is released.
- Asynchronous reset mid-run clears everything immediately. No pulse may be emitted after reset.

## Test plan
- Reset then read STATUS → 0x0; read CTRL → 0x0; all outputs 0.
- CTRL=0x0000_010D (num_ts=1, mask=3, start) → one spike_latch_o pulse; axon_idx 0..255 with calc_en=01, then 0..255 with calc_en=10; one spike_capture_o pulse; done at t+516; STATUS=0x0000_0102.
- num_ts=3, mask=2'b10 → core 1 only, 3 latch/capture pairs; ts_done=3; total 3×259 cycles.
- Hold calc_stall_i high for 5 cycles at axon 255 of core 0 → idx stays 255 with calc_en=01 for 6 cycles, then idx=0 with calc_en=10.
- Abort at axon 100 of timestep 2 → IDLE next cycle, no capture pulse, busy=0, done=0, ts_done=1.
- Start with mask=0 → err=1, busy=0. Start during a run → ignored. Access to CTRL_BASE+8 → no ack.
